// File: rtl/div_sequencer_if.sv
// Pipeline-side handshake and result bus for the multi-cycle divider.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             stall;
    logic             result_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // EX stage drives requests and observes the hold and result
    modport master (
        output start, signed_div, dividend, divisor, annul,
        input  stall, result_valid, hi, lo
    );

    // Divider sequencer side
    modport slave (
        input  start, signed_div, dividend, divisor, annul,
        output stall, result_valid, hi, lo
    );
endinterface

// File: rtl/div_sequencer.sv
// DIV/DIVU sequencer: radix-2 restoring divide over WIDTH cycles, stalling
// the pipeline while busy and pulsing result_valid with LO=quotient, HI=remainder.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          resetn,
    div_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgnq_q, sgnq_d;
    logic             sgnr_q, sgnr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // Request acceptance, operand magnitudes and one restoring-divide step
    always_comb begin
        accept    = (state_q == S_IDLE) && bus.start && !bus.annul;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
        dvd_mag   = (bus.signed_div && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        dvs_mag   = (bus.signed_div && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
        // Shifted remainder needs WIDTH+1 bits; the top bit of the difference is the borrow.
        trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_nx    = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        quo_nx    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Next-state logic; annul overrides everything except the datapath scratch registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_d  = '0;
                    quo_d  = dvd_mag;
                    dvs_d  = dvs_mag;
                    sgnq_d = bus.signed_div && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    sgnr_d = bus.signed_div && bus.dividend[WIDTH-1];
                    cnt_d  = '0;
                    if (bus.divisor == '0) begin
                        state_d = S_DONE;
                        lo_d    = '1;
                        hi_d    = bus.dividend;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                    lo_d    = sgnq_q ? -quo_nx : quo_nx;
                    hi_d    = sgnr_q ? -rem_nx : rem_nx;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.annul) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall is forced low while reset is asserted so the pipeline is released at once
    assign bus.stall        = resetn && (accept || ((state_q == S_RUN) && !bus.annul));
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a transaction-level reference model
// checked on every cycle plus literal expectations at each result.
module tb_div_sequencer;
    logic clk;
    logic resetn;

    div_sequencer_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: busy flag with remaining-cycle count, and visible hi/lo
    bit          m_run;
    bit          m_done;
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // MIPS DIV/DIVU result from plain arithmetic
    task automatic div_ref(input logic [31:0] a, input logic [31:0] b, input bit s,
                           output logic [31:0] rh, output logic [31:0] rl);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) begin
            rl = 32'hFFFF_FFFF;
            rh = a;
        end else if (s) begin
            ma = a[31] ? (32'd0 - a) : a;
            mb = b[31] ? (32'd0 - b) : b;
            q  = ma / mb;
            r  = ma % mb;
            rl = (a[31] ^ b[31]) ? (32'd0 - q) : q;
            rh = a[31] ? (32'd0 - r) : r;
        end else begin
            rl = a / b;
            rh = a % b;
        end
    endtask

    // Per-cycle compare at the falling edge, then advance the model across the next rising edge
    task automatic model_step();
        bit exp_stall, exp_valid;
        if (!resetn) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end
        exp_valid = m_done;
        exp_stall = resetn && !bus.annul &&
                    (m_run || (!m_done && bus.start));
        chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
        chk("result_valid", {31'd0, bus.result_valid}, {31'd0, exp_valid});
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
        if (!resetn) return;
        if (bus.annul) begin
            m_run  = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_hi   = p_hi;
                m_lo   = p_lo;
            end
        end else if (bus.start) begin
            div_ref(bus.dividend, bus.divisor, bus.signed_div, p_hi, p_lo);
            if (bus.divisor == 32'd0) begin
                m_done = 1'b1;
                m_hi   = p_hi;
                m_lo   = p_lo;
            end else begin
                m_run  = 1'b1;
                m_left = 32;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input bit s);
        bus.dividend   = a;
        bus.divisor    = b;
        bus.signed_div = s;
        bus.start      = 1'b1;
        #1;
        chk("stall_on_accept", {31'd0, bus.stall}, 32'd1);
    endtask

    // Wait (bounded) for result_valid; check latency from the accept cycle and the result
    task automatic wait_valid(input string nm, input int exp_lat,
                              input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                              input bit drop);
        int k;
        k = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            k = i;
            if (bus.result_valid) break;
            if (i == 80) k = 81;
        end
        chk({nm, "_latency"}, 32'(k), 32'(exp_lat));
        chk({nm, "_lo"}, bus.lo, exp_lo);
        chk({nm, "_hi"}, bus.hi, exp_hi);
        if (drop) begin
            bus.start = 1'b0;
            tick();
        end
    endtask

    initial begin
        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.annul      = 1'b0;
        m_run = 1'b0; m_done = 1'b0; m_left = 0;
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0;
        tick();
        tick();
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_valid", {31'd0, bus.result_valid}, 32'd0);
        resetn = 1'b1;
        tick();

        // Unsigned 100/7
        start_req(32'd100, 32'd7, 1'b0);
        wait_valid("divu_100_7", 33, 32'd14, 32'd2, 1'b1);
        chk("divu_stall_in_done", {31'd0, bus.stall}, 32'd0);

        // Signed -7/2 and the overflow case
        start_req(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_valid("div_m7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        start_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_valid("div_ovf", 33, 32'h8000_0000, 32'h0000_0000, 1'b1);

        // Divide by zero completes in one cycle
        start_req(32'h0000_1234, 32'd0, 1'b0);
        wait_valid("divu_by0", 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

        // Annul during RUN, then a fresh request the following cycle
        start_req(32'd1000, 32'd3, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        bus.annul = 1'b1;
        #1;
        chk("annul_stall_low", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.annul    = 1'b0;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        #1;
        chk("annul_keeps_lo", bus.lo, 32'hFFFF_FFFF);
        chk("annul_keeps_hi", bus.hi, 32'h0000_1234);
        wait_valid("after_annul", 33, 32'd14, 32'd2, 1'b1);

        // start held through DONE: no re-trigger in DONE, next accept in the IDLE cycle after
        start_req(32'd50000, 32'd9, 1'b0);
        bus.dividend = 32'd50000;
        wait_valid("held_first", 33, 32'd5555, 32'd5, 1'b0);
        bus.dividend = 32'hFFFF_FFFF;
        bus.divisor  = 32'h0000_0010;
        wait_valid("held_second", 34, 32'h0FFF_FFFF, 32'h0000_000F, 1'b1);

        // Asynchronous reset mid-operation
        start_req(32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_stall", {31'd0, bus.stall}, 32'd0);
        chk("arst_valid", {31'd0, bus.result_valid}, 32'd0);
        chk("arst_hi", bus.hi, 32'd0);
        chk("arst_lo", bus.lo, 32'd0);
        @(negedge clk);
        model_step();
        #2;
        resetn    = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        tick();

        // Back in IDLE: a plain unsigned divide with full latency
        start_req(32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_valid("post_reset", 33, 32'h7FFF_FFFC, 32'd1, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
